// File: rtl/timer_sequencer_if.sv
// Bundle of mode-control signals between the countdown timer sequencer and
// the rest of the timer (buttons, programming block, digit driver).
interface timer_sequencer_if;
    logic        start_stop;    // single-cycle button pulse
    logic        toggle;        // single-cycle button pulse
    logic        programmed;    // level: value entry complete
    logic [15:0] progDigits;    // {min, sec} from the programming block
    logic [2:0]  currentState;  // active mode
    logic [15:0] digitsOut;     // display value {min, sec}
    logic        alarm;         // high while in ALARM
    logic        done;          // one-cycle pulse on RUN->ALARM

    // Environment side: drives buttons/programming data, observes the mode.
    modport master (
        output start_stop, toggle, programmed, progDigits,
        input  currentState, digitsOut, alarm, done
    );

    // Sequencer side.
    modport slave (
        input  start_stop, toggle, programmed, progDigits,
        output currentState, digitsOut, alarm, done
    );
endinterface

// File: rtl/timer_sequencer.sv
// Top-level mode controller of the countdown timer: IDLE/PROG/RUN/PAUSE/ALARM
// sequencing, minute/second count with 1 Hz prescaler, display multiplexing.
//
// Handshake: there is no valid/ready pair here; start_stop and toggle are
// single-cycle pulses sampled on every rising clk edge, programmed is a level
// sampled only in PROG once the guard window has elapsed. Every state change
// becomes visible the cycle after the qualifying input.
module timer_sequencer #(
    parameter int TICK_DIV   = 50000000,
    parameter int ALARM_SECS = 30,
    parameter int PROG_GUARD = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    timer_sequencer_if.slave  bus
);

    localparam int PW = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
    localparam int AW = ($clog2(ALARM_SECS + 1) < 1) ? 1 : $clog2(ALARM_SECS + 1);
    localparam int GW = ($clog2(PROG_GUARD + 1) < 1) ? 1 : $clog2(PROG_GUARD + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_END  = AW'(ALARM_SECS);
    localparam logic [GW-1:0] GUARD_INIT = GW'(PROG_GUARD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PROG  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_ALARM = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          done_q, done_d;

    logic          tick;
    logic [7:0]    dec_min;
    logic [7:0]    dec_sec;
    logic          dec_zero;
    logic          count_nonzero;
    logic [AW-1:0] alarm_cnt_inc;

    // Entered minutes/seconds above 59 are saturated rather than wrapped.
    function automatic logic [7:0] clamp59(input logic [7:0] v);
        return (v > 8'd59) ? 8'd59 : v;
    endfunction

    assign tick          = (presc_q == PRESC_LAST);
    assign count_nonzero = (min_q != 8'd0) || (sec_q != 8'd0);
    assign alarm_cnt_inc = alarm_cnt_q + 1'b1;

    // One-second decrement of the {min, sec} count, borrowing a minute at :00.
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q != 8'd0) begin
            dec_sec = sec_q - 8'd1;
        end else if (min_q != 8'd0) begin
            dec_min = min_q - 8'd1;
            dec_sec = 8'd59;
        end
        dec_zero = (dec_min == 8'd0) && (dec_sec == 8'd0);
    end

    // Next-state and next-count logic for the mode FSM.
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        sec_d       = sec_q;
        presc_d     = presc_q;
        guard_d     = guard_q;
        alarm_cnt_d = alarm_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // toggle has priority over start_stop
                if (bus.toggle) begin
                    state_d = S_PROG;
                    guard_d = GUARD_INIT;
                end else if (bus.start_stop && count_nonzero) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end

            S_PROG: begin
                // guard window hides the programming block's stale level
                if (guard_q != '0) begin
                    guard_d = guard_q - 1'b1;
                end else if (bus.programmed) begin
                    min_d   = clamp59(bus.progDigits[15:8]);
                    sec_d   = clamp59(bus.progDigits[7:0]);
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                if (tick) begin
                    // the decrement always lands; reaching 00:00 beats a pause
                    min_d   = dec_min;
                    sec_d   = dec_sec;
                    presc_d = '0;
                    if (dec_zero) begin
                        state_d     = S_ALARM;
                        done_d      = 1'b1;
                        alarm_cnt_d = '0;
                    end else if (bus.start_stop) begin
                        state_d = S_PAUSE;
                    end
                end else if (bus.start_stop) begin
                    // prescaler held so the partial second resumes later
                    state_d = S_PAUSE;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            S_PAUSE: begin
                if (bus.toggle) begin
                    state_d = S_IDLE;
                    min_d   = 8'd0;
                    sec_d   = 8'd0;
                end else if (bus.start_stop) begin
                    state_d = S_RUN;
                end
            end

            S_ALARM: begin
                if (bus.start_stop || bus.toggle) begin
                    state_d = S_IDLE;
                    min_d   = 8'd0;
                    sec_d   = 8'd0;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (alarm_cnt_inc == ALARM_END) begin
                            state_d = S_IDLE;
                        end else begin
                            alarm_cnt_d = alarm_cnt_inc;
                        end
                    end
                end
            end

            default: begin
                // unreachable encodings recover to a cleared IDLE
                state_d = S_IDLE;
                min_d   = 8'd0;
                sec_d   = 8'd0;
                presc_d = '0;
            end
        endcase
    end

    // State, count and pulse registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            min_q       <= 8'd0;
            sec_q       <= 8'd0;
            presc_q     <= '0;
            guard_q     <= '0;
            alarm_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            presc_q     <= presc_d;
            guard_q     <= guard_d;
            alarm_cnt_q <= alarm_cnt_d;
            done_q      <= done_d;
        end
    end

    assign bus.currentState = state_q;
    assign bus.digitsOut    = (state_q == S_PROG) ? bus.progDigits : {min_q, sec_q};
    assign bus.alarm        = (state_q == S_ALARM);
    assign bus.done         = done_q;

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Top-level mode controller for the countdown timer.
- Owns the 3-bit state bus that selects which sub-block is active, and hands control to the programming block.
- Latches the programmed minutes/seconds and runs the 1 Hz countdown, pause and alarm phases.
- Multiplexes the 16-bit display value to the digit driver.

Parameters:
- TICK_DIV, 50000000: clk cycles per countdown second (prescaler terminal count + 1); must be >= 2.
- ALARM_SECS, 30: seconds the alarm stays asserted before auto-return to IDLE.
- PROG_GUARD, 3: cycles after entering PROG during which `programmed` is ignored (covers the programming block's state-change latency).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start_stop, input, 1: synchronized single-cycle button pulse.
- toggle, input, 1: synchronized single-cycle button pulse.
- programmed, input, 1: level from the programming block; 1 = value entry complete.
- progDigits, input, 16: {min[7:0], sec[7:0]} from the programming block, binary 0..59 each.
- currentState, output, 3: active mode: 0 IDLE, 1 PROG, 2 RUN, 3 PAUSE, 4 ALARM.
- digitsOut, output, 16: display value {min, sec}.
- alarm, output, 1: high while in ALARM.
- done, output, 1: one-cycle pulse on the RUN->ALARM transition.

Behaviour:
- Reset (async, rst_n=0):
  - currentState=IDLE; min=sec=0; prescaler=0; guard counter=0; alarm counter=0.
  - alarm=0; done=0; digitsOut=16'h0000.
  - Deassertion is effective on the next clk edge.
- All state, count and output registers are registered; transitions take effect the cycle after the qualifying input.
- Encodings 5..7 are unreachable; if ever entered, next state is IDLE with count cleared.
- IDLE:
  - toggle -> PROG; guard counter loads PROG_GUARD.
  - start_stop with {min,sec} != 0 -> RUN; prescaler cleared.
  - start_stop with 00:00 is ignored.
  - Both pulses in the same cycle -> toggle wins.
- PROG:
  - Guard counter decrements to 0; `programmed` is ignored while guard != 0.
  - Once guard == 0 and programmed == 1: min <= progDigits[15:8], sec <= progDigits[7:0], next state IDLE.
  - start_stop and toggle are ignored in PROG; toggle belongs to the programming block.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. On the wrap cycle ("tick"):
    - sec>0: sec--.
    - sec==0, min>0: min--, sec=59.
  - A tick that produces 00:00 -> ALARM, done=1 for that one cycle, alarm counter=0.
  - start_stop -> PAUSE; prescaler value is held, not cleared.
  - start_stop on a tick cycle: the decrement is applied. If that decrement reaches 00:00, ALARM wins over PAUSE.
  - toggle in RUN is ignored.
- PAUSE:
  - Count and prescaler are frozen.
  - start_stop -> RUN; prescaler resumes from its held value.
  - toggle -> IDLE with min=sec=0.
  - Both pulses in the same cycle -> toggle wins.
- ALARM:
  - alarm=1.
  - The prescaler keeps running; each tick increments the alarm counter.
  - Alarm counter reaching ALARM_SECS -> IDLE.
  - start_stop or toggle -> IDLE immediately.
  - alarm=0 from the cycle IDLE is entered; count stays 00:00.
- digitsOut: progDigits when currentState==PROG, else {min, sec}.
- Width rules:
  - min/sec are 8-bit binary and never exceed 59.
  - progDigits values >59 are clamped to 59 on latch.
- Counter widths:
  - Prescaler: clog2(TICK_DIV) bits.
  - Alarm counter: clog2(ALARM_SECS+1) bits.
  - Guard counter: clog2(PROG_GUARD+1) bits.
- Reset mid-operation (any state) returns to the full reset values in the same instant, without waiting for clk.

Test Plan:
Bench uses TICK_DIV=4, ALARM_SECS=3, PROG_GUARD=3.
1. Reset, then toggle pulse -> currentState=1 next cycle. Hold programmed=1 from entry, progDigits=16'h0102 -> no latch for 3 cycles, then min=1, sec=2, state=0, digitsOut=16'h0102.
2. From 01:02 in IDLE, start_stop -> RUN. Expected sequence: 01:01 after 4 cycles, 01:00 after 8, then 00:59 with min borrow, and so on. At 00:00: state=4, done high exactly 1 cycle, alarm=1.
3. ALARM with no input -> alarm=1 for exactly 3 ticks (12 cycles), then state=0, alarm=0.
4. RUN at 00:05, prescaler=2, then start_stop -> PAUSE. Wait 20 cycles: digits unchanged. start_stop -> RUN; first decrement 2 cycles later. toggle in PAUSE -> IDLE, digitsOut=0.
5. Edge cases:
   - start_stop in IDLE at 00:00 -> stays IDLE.
   - toggle+start_stop together in IDLE -> PROG.
   - start_stop coinciding with the tick that reaches 00:00 -> ALARM, not PAUSE.
   - progDigits=16'h4A63 latched -> digitsOut=16'h3B3B.
6. Assert rst_n=0 mid-RUN between clk edges -> state=0, digitsOut=0, alarm=0 immediately. After release, toggle -> PROG resumes normal operation.
